// File: rtl/crc32_pkg.sv
// ---------------------------------------------------------------------------
// crc32_pkg
// Shared constants and types for the CRC32 FCS inserter and its engine.
//   CRC_INIT    : LFSR preset loaded at the first word of a frame
//   POLY        : CRC-32 generator polynomial (MSB-first, non-reflected)
//   CRC_LATENCY : cycles the inserter waits after eop before sampling the engine
//   CRC_RESIDUE : raw LFSR state after a frame plus its appended FCS
//   state_t     : inserter FSM state encoding
// ---------------------------------------------------------------------------
package crc32_pkg;

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] POLY        = 32'h04C1_1DB7;
   localparam logic [1:0]  CRC_LATENCY = 2'd2;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PASS     = 2'd1,
      ST_WAIT_CRC = 2'd2,
      ST_APPEND   = 2'd3
   } state_t;

endpackage

// File: rtl/crc32_fcs_inserter.sv
// ---------------------------------------------------------------------------
// crc32_fcs_inserter
// Forwards a word-aligned frame stream, feeds every payload word to an
// external CRC32 engine, and appends the inverted engine state as a trailing
// FCS word marked with m_last.
//
// Ports
//   clk, reset_n                  : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data        : upstream stream, s_sop/s_eop frame marks
//   crc_enable/crc_sop/crc_data   : engine drive (one word per enable, no stall)
//   crc_value                     : raw LFSR state returned by the engine
//   m_valid/m_ready/m_data/m_last : downstream stream with FCS appended
//   proto_err                     : one-cycle pulse on a framing violation
//   frame_cnt                     : completed frames (wraps at 16 bits)
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for a sop word; non-sop words are dropped
// ST_PASS     | forwarding payload through the single output register
// ST_WAIT_CRC | eop taken; counting down until the engine state is final
// ST_APPEND   | emitting the FCS word once the output register is free
// ---------------------------------------------------------------------------
module crc32_fcs_inserter
   import crc32_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,

   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_sop,
   input  logic        s_eop,

   output logic        crc_enable,
   output logic        crc_sop,
   output logic [31:0] crc_data,
   input  logic [31:0] crc_value,

   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        m_last,

   output logic        proto_err,
   output logic [15:0] frame_cnt
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_cnt;
   logic [31:0] r_fcs_q;
   logic        r_rst_done;

   logic        r_m_valid;
   logic [31:0] r_m_data;
   logic        r_m_last;
   logic [15:0] r_frame_cnt;

   logic        w_out_free;
   logic        w_s_ready;
   logic        w_acc;
   logic        w_fwd;
   logic        w_first;
   logic        w_err;
   logic        w_load_fcs;
   logic        w_fcs_xfer;

   // ---------------------------------------------------------------------
   // Next-state and handshake decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_out_free  = !r_m_valid || m_ready;
      w_s_ready   = 1'b0;
      w_acc       = 1'b0;
      w_fwd       = 1'b0;
      w_first     = 1'b0;
      w_err       = 1'b0;
      w_load_fcs  = 1'b0;
      w_fcs_xfer  = 1'b0;

      // r_rst_done keeps s_ready low until the first clock after reset.
      case (r_state)
         ST_IDLE: w_s_ready = r_rst_done;
         ST_PASS: w_s_ready = w_out_free;
         default: w_s_ready = 1'b0;
      endcase

      w_acc = s_valid && w_s_ready;

      case (r_state)
         ST_IDLE: begin
            if (w_acc) begin
               if (s_sop) begin
                  w_fwd       = 1'b1;
                  w_first     = 1'b1;
                  w_state_nxt = s_eop ? ST_WAIT_CRC : ST_PASS;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         ST_PASS: begin
            if (w_acc) begin
               // A repeated sop is flagged but carried as ordinary payload.
               w_fwd = 1'b1;
               w_err = s_sop;
               if (s_eop) begin
                  w_state_nxt = ST_WAIT_CRC;
               end
            end
         end
         ST_WAIT_CRC: begin
            if (r_cnt == 2'd0) begin
               w_state_nxt = ST_APPEND;
            end
         end
         ST_APPEND: begin
            if (r_m_valid && r_m_last) begin
               if (m_ready) begin
                  w_fcs_xfer  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_out_free) begin
               w_load_fcs = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // State, wait counter and FCS capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 2'd0;
         r_fcs_q    <= 32'd0;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rst_done <= 1'b1;
         if (w_fwd && s_eop) begin
            r_cnt <= CRC_LATENCY;
         end else if (r_state == ST_WAIT_CRC && r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
         end
         if (r_state == ST_WAIT_CRC && r_cnt == 2'd0) begin
            r_fcs_q <= ~crc_value;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output register and frame counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_m_valid   <= 1'b0;
         r_m_data    <= 32'd0;
         r_m_last    <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         if (w_fwd) begin
            r_m_valid <= 1'b1;
            r_m_data  <= s_data;
            r_m_last  <= 1'b0;
         end else if (w_load_fcs) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_fcs_q;
            r_m_last  <= 1'b1;
         end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
         end
         if (w_fcs_xfer) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign s_ready    = w_s_ready;
   assign crc_enable = w_fwd;
   assign crc_sop    = w_first;
   assign crc_data   = w_fwd ? s_data : 32'd0;
   assign proto_err  = w_err;
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign m_last     = r_m_last;
   assign frame_cnt  = r_frame_cnt;

endmodule
